// File: rtl/mod7_pkg.sv
// mod7_pkg: shared types, constants and helpers for the mod-7 exponentiation sequencer.
package mod7_pkg;

    typedef logic [2:0] residue_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SQUARE = 2'd1,
        ST_MULT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam residue_t RES_ONE = 3'd1;

    // 7 and 0 are the same residue; fold 7 onto 0 so results stay in 0..6.
    function automatic residue_t normalize(residue_t v);
        return (v == 3'd7) ? 3'd0 : v;
    endfunction

endpackage

// File: rtl/mod7_mul.sv
// mod7_mul: combinational residue multiplier. Because 8 == 1 (mod 7), the
// high octal digit of the product is folded onto the low digit (end-around carry).
// The output may be 7, which stands for 0; the caller normalizes.
module mod7_mul
    import mod7_pkg::*;
(
    input  residue_t i_a,
    input  residue_t i_b,
    output residue_t o_p
);

    logic [5:0] w_prod;
    logic [3:0] w_fold1;
    logic [2:0] w_fold2;

    assign w_prod  = {3'b000, i_a} * {3'b000, i_b};
    // First fold: at most 6 + 1 = 7 and 7 + 7 = 14, so a carry may remain.
    assign w_fold1 = {1'b0, w_prod[5:3]} + {1'b0, w_prod[2:0]};
    // Second fold: when a carry exists the low digit is at most 6, so this fits in 3 bits.
    assign w_fold2 = {2'b00, w_fold1[3]} + w_fold1[2:0];
    assign o_p     = w_fold2;

endmodule

// File: rtl/mod7_exp_ctrl.sv
// mod7_exp_ctrl: square-and-multiply sequencer computing base^exponent mod 7,
// scanning the exponent MSB-first with one shared mod-7 multiply per clock.
// Optional build macro: MOD7_EXP_ZERO_EXIT_EN -- finish early once the
// accumulator becomes 0 (the result cannot change after that).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request, in_ready high
// ST_SQUARE | acc <= acc*acc for the current exponent bit
// ST_MULT   | acc <= acc*base for a set exponent bit
// ST_DONE   | result presented, held until out_ready
module mod7_exp_ctrl
    import mod7_pkg::*;
#(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       base,
    input  logic [EXP_W-1:0] exponent,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       result,
    output logic             busy
);

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(EXP_W - 1);

    state_e           r_state;
    residue_t         r_acc;
    residue_t         r_base_q;
    logic [EXP_W-1:0] r_exp_q;
    logic [IDX_W-1:0] r_idx;

    state_e           w_state_nxt;
    residue_t         w_acc_nxt;
    residue_t         w_base_nxt;
    logic [EXP_W-1:0] w_exp_nxt;
    logic [IDX_W-1:0] w_idx_nxt;

    residue_t         w_mul_a;
    residue_t         w_mul_b;
    residue_t         w_mul_p;
    residue_t         w_mul_n;
    logic             w_bit;
    logic             w_last;

    mod7_mul u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_mul_p)
    );

    assign w_mul_n = normalize(w_mul_p);
    assign w_bit   = r_exp_q[r_idx];
    assign w_last  = (r_idx == '0);

    // Next-state, datapath updates and handshake outputs; multiplier operands are zero outside the compute states.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_base_nxt  = r_base_q;
        w_exp_nxt   = r_exp_q;
        w_idx_nxt   = r_idx;
        w_mul_a     = '0;
        w_mul_b     = '0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        result      = '0;
        busy        = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                in_ready = !rst;
                if (in_valid && !rst) begin
                    w_base_nxt  = normalize(base);
                    w_exp_nxt   = exponent;
                    w_acc_nxt   = RES_ONE;
                    w_idx_nxt   = IDX_MSB;
                    w_state_nxt = ST_SQUARE;
                end
            end

            ST_SQUARE: begin
                w_mul_a   = r_acc;
                w_mul_b   = r_acc;
                w_acc_nxt = w_mul_n;
                if (w_bit) begin
                    w_state_nxt = ST_MULT;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt = r_idx - 1'b1;
                end
`ifdef MOD7_EXP_ZERO_EXIT_EN
                if (w_mul_n == '0) begin
                    w_state_nxt = ST_DONE;
                end
`endif
            end

            ST_MULT: begin
                w_mul_a   = r_acc;
                w_mul_b   = r_base_q;
                w_acc_nxt = w_mul_n;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_nxt   = r_idx - 1'b1;
                    w_state_nxt = ST_SQUARE;
                end
`ifdef MOD7_EXP_ZERO_EXIT_EN
                if (w_mul_n == '0) begin
                    w_state_nxt = ST_DONE;
                end
`endif
            end

            ST_DONE: begin
                out_valid = 1'b1;
                result    = r_acc;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_base_q <= '0;
            r_exp_q  <= '0;
            r_idx    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_base_q <= w_base_nxt;
            r_exp_q  <= w_exp_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

endmodule

// File: tb/tb_mod7_exp_ctrl.sv
// tb_mod7_exp_ctrl: directed and random requests checked against an
// arithmetic model of base^exponent mod 7 and its expected latency.
module tb_mod7_exp_ctrl;

    localparam int EXP_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       base;
    logic [EXP_W-1:0] exponent;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       result;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod7_exp_ctrl #(.EXP_W(EXP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .exponent  (exponent),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Repeated multiplication; 0^0 is 1 because the loop never runs.
    function automatic int ref_pow(input int b, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * (b % 7)) % 7;
        return r;
    endfunction

    // Cycle offset from the accept cycle to the first out_valid cycle.
    function automatic int ref_lat(input int b, input int e);
        int pop;
        pop = 0;
        for (int i = 0; i < EXP_W; i++) pop += (e >> i) & 1;
`ifdef MOD7_EXP_ZERO_EXIT_EN
        // A zero base zeroes the accumulator at the multiply for the highest set bit.
        if ((b % 7) == 0 && e != 0) begin
            int k;
            k = 0;
            for (int i = 0; i < EXP_W; i++) if (((e >> i) & 1) != 0) k = i;
            return 1 + (EXP_W - k) + 1;
        end
`endif
        return 1 + EXP_W + pop;
    endfunction

    task automatic run_req(input int b, input int e, input int hold);
        int n;
        int exp_res;
        exp_res = ref_pow(b, e);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", in_ready, 1);
        base      = 3'(b);
        exponent  = EXP_W'(e);
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        n = 1;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, ref_lat(b, e));
        chk("result", result, exp_res);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = 1'($urandom_range(0, 1));
                base     = 3'($urandom);
                exponent = EXP_W'($urandom);
                @(posedge clk);
                #1;
                chk("hold_result", result, exp_res);
                chk("hold_out_valid", out_valid, 1);
                chk("hold_in_ready", in_ready, 0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("after_take_busy", busy, 0);
        chk("after_take_out_valid", out_valid, 0);
        chk("after_take_in_ready", in_ready, 1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base      = '0;
        exponent  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        run_req(3, 5, 0);
        run_req(3, 6, 0);
        run_req(5, 255, 0);
        run_req(0, 0, 0);
        run_req(7, 4, 0);
        run_req(7, 8'h80, 0);
        run_req(4, 9, 5);

        // Abort in the middle of a computation.
        @(negedge clk);
        base     = 3'd3;
        exponent = 8'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_release_in_ready", in_ready, 1);
        run_req(2, 3, 0);

        for (int i = 0; i < 24; i++) begin
            run_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
